// File: rtl/mux_demux_pkg.sv
// Shared slot/channel constants for the TDM mux/demux link.
// Slot index type, channel count, slot constants and slot increment helper.
package mux_demux_pkg;

  localparam int SLOT_W = 2;
  localparam int NCH    = 4;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t SLOT0 = 2'd0;
  localparam slot_t SLOT1 = 2'd1;
  localparam slot_t SLOT2 = 2'd2;
  localparam slot_t SLOT3 = 2'd3;

  function automatic slot_t slot_inc(slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux: advances on en, loads 1 on sync.
// Ports: clk, rst (async high), en, sync -> slot, misalign (sync & slot!=0).
module tdm_slot_ctr
  import mux_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  sync,
  output slot_t slot,
  output logic  misalign
);

  assign misalign = sync & (slot != SLOT0);

  // A synced sample occupies slot 0, so the next one is slot 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= SLOT0;
    end else if (en) begin
      slot <= sync ? SLOT1 : slot_inc(slot);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer with sync lock, realign and frame assembly.
// Ports: clk, rst, din, din_valid, sync -> o, frame, frame_valid, slot, locked, sync_err.
module tdm_demux4
  import mux_demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [4*W-1:0] o,
  output logic [4*W-1:0] frame,
  output logic         frame_valid,
  output slot_t        slot,
  output logic         locked,
  output logic         sync_err
);

  slot_t        u;
  logic         misalign;
  logic         realign;
  logic         publish;
  logic         discard;
  logic [W-1:0] shadow [3];

  tdm_slot_ctr u_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (din_valid),
    .sync     (sync),
    .slot     (slot),
    .misalign (misalign)
  );

  assign u       = sync ? SLOT0 : slot;
  assign realign = din_valid & misalign & locked;
  assign publish = din_valid & (u == SLOT3)
                 & locked & ~discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o           <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      discard     <= 1'b0;
      for (int i = 0; i < 3; i++)
        shadow[i] <= '0;
    end else begin
      frame_valid <= publish;
      sync_err    <= realign;
      if (din_valid) begin
        o[int'(u)*W +: W] <= din;
        discard <= realign;
        if (sync)
          locked <= 1'b1;
        // Drop the broken partial frame; slot 0 is rewritten below.
        if (realign) begin
          shadow[1] <= '0;
          shadow[2] <= '0;
        end
        unique case (u)
          SLOT0: shadow[0] <= din;
          SLOT1: shadow[1] <= din;
          SLOT2: shadow[2] <= din;
          SLOT3: ;
        endcase
        if (publish)
          frame <= {din, shadow[2], shadow[1], shadow[0]};
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W=8) against a slot/frame model.
// Directed vectors plus per-cycle compare of every output.
module tb_tdm_demux4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           sync = 1'b0;
  logic [4*W-1:0] o;
  logic [4*W-1:0] frame;
  logic           frame_valid;
  logic [1:0]     slot;
  logic           locked;
  logic           sync_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .o           (o),
    .frame       (frame),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int             m_slot;
  logic [4*W-1:0] m_o;
  logic [4*W-1:0] m_frame;
  logic [W-1:0]   m_sh [4];
  bit             m_fv, m_lock, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot = 0; m_o = '0; m_frame = '0;
      m_fv = 0; m_lock = 0; m_err = 0;
      for (int k = 0; k < 4; k++) m_sh[k] = '0;
    end else begin
      int uu;
      m_fv = 0;
      m_err = 0;
      if (din_valid) begin
        uu = sync ? 0 : m_slot;
        if (sync && m_slot != 0 && m_lock) begin
          m_err = 1;
          for (int k = 1; k < 4; k++) m_sh[k] = '0;
        end
        m_o[uu*W +: W] = din;
        m_sh[uu] = din;
        if (uu == 3 && m_lock) begin
          m_frame = {din, m_sh[2], m_sh[1], m_sh[0]};
          m_fv = 1;
        end
        if (sync) m_lock = 1;
        m_slot = (uu + 1) % 4;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (!rst) begin
      chk("m_o", o, m_o);
      chk("m_frame", frame, m_frame);
      chk("m_fv", 32'(frame_valid), 32'(m_fv));
      chk("m_slot", 32'(slot), 32'(m_slot));
      chk("m_lock", 32'(locked), 32'(m_lock));
      chk("m_err", 32'(sync_err), 32'(m_err));
    end
  end

  task automatic step(input logic [W-1:0] d,
                      input logic v, input logic s);
    din = d;
    din_valid = v;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = '0; din_valid = 1'b0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int f0;

  initial begin
    do_reset();
    chk("rst_o", o, 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_lock", 32'(locked), 32'h0);

    // Test 1: sync on first sample, continuous stream 1,0,1,1
    step(8'h01, 1, 1);
    chk("t1_lock", 32'(locked), 32'h1);
    step(8'h00, 1, 0);
    step(8'h01, 1, 0);
    step(8'h01, 1, 0);
    chk("t1_frame", frame, 32'h01010001);
    chk("t1_fv", 32'(frame_valid), 32'h1);
    chk("t1_o", o, 32'h01010001);
    chk("t1_slot", 32'(slot), 32'h0);
    step(8'h00, 0, 0);
    chk("t1_fv_off", 32'(frame_valid), 32'h0);

    // Test 2: aligned frame with gaps in din_valid
    f0 = fv_cnt;
    step(8'h0A, 1, 1);
    step(8'hFF, 0, 0);
    chk("t2_hold", 32'(slot), 32'h1);
    step(8'h05, 1, 0);
    step(8'hFF, 0, 0);
    step(8'h03, 1, 0);
    step(8'hFF, 0, 0);
    chk("t2_hold3", 32'(slot), 32'h3);
    step(8'h0C, 1, 0);
    chk("t2_frame", frame, 32'h0C03050A);
    step(8'h00, 0, 0);
    step(8'h00, 0, 0);
    chk("t2_pulses", 32'(fv_cnt - f0), 32'h1);

    // Test 3: no sync, 8 samples, nothing published
    do_reset();
    f0 = fv_cnt;
    for (int i = 1; i <= 8; i++) begin
      step(8'(i), 1, 0);
      chk("t3_o", 32'(o[((i-1)%4)*W +: W]), 32'(i));
    end
    chk("t3_slot", 32'(slot), 32'h0);
    chk("t3_frame", frame, 32'h0);
    chk("t3_lock", 32'(locked), 32'h0);
    chk("t3_pulses", 32'(fv_cnt - f0), 32'h0);

    // Test 4: misaligned sync mid-frame
    do_reset();
    step(8'h07, 1, 1);
    step(8'h02, 1, 0);
    chk("t4_slot2", 32'(slot), 32'h2);
    step(8'h01, 1, 1);
    chk("t4_err", 32'(sync_err), 32'h1);
    chk("t4_o0", 32'(o[0 +: W]), 32'h1);
    chk("t4_slot", 32'(slot), 32'h1);
    chk("t4_fv", 32'(frame_valid), 32'h0);
    step(8'h00, 1, 0);
    chk("t4_err_off", 32'(sync_err), 32'h0);
    step(8'h01, 1, 0);
    step(8'h01, 1, 0);
    chk("t4_frame", frame, 32'h01010001);
    chk("t4_fv2", 32'(frame_valid), 32'h1);

    // Test 5: sync without valid, then async reset
    step(8'h01, 1, 1);
    step(8'h00, 1, 0);
    step(8'h05, 0, 1);
    chk("t5_noerr", 32'(sync_err), 32'h0);
    chk("t5_slot", 32'(slot), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t5_o", o, 32'h0);
    chk("t5_frame", frame, 32'h0);
    chk("t5_slot0", 32'(slot), 32'h0);
    chk("t5_lock", 32'(locked), 32'h0);
    do_reset();

    // Test 6: 12 samples, aligned sync every 4th
    for (int i = 0; i < 12; i++) begin
      step(8'(8'h10 + i), 1, (i % 4) == 0);
      chk("t6_fv", 32'(frame_valid), 32'((i % 4) == 3));
      chk("t6_err", 32'(sync_err), 32'h0);
    end
    chk("t6_frame", frame, 32'h1B1A1918);
    step(8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
